ps2_host_transmitter: RTL and testbench



---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_line_sync.sv | 30 +++
 rtl/ps2_host_transmitter.sv | 189 ++++++++++++++++++
 tb/tb_ps2_host_transmitter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types, default timing constants and command bytes for the PS/2 host transmitter.
// The optional timeout supervision is enabled by defining PS2_TX_TIMEOUT_EN.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAITIDLE,
    ERR
  } ps2_tx_state_e;

  // Defaults assume a 50 MHz system clock.
  localparam int PS2_INHIBIT_CYCLES_DEF       = 6000;
  localparam int PS2_START_TIMEOUT_CYCLES_DEF = 750000;
  localparam int PS2_XFER_TIMEOUT_CYCLES_DEF  = 100000;

  localparam int PS2_TMR_W    = 20;
  localparam int PS2_BITCNT_W = 4;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pin plus a falling-edge detector on the
// synchronized level. Flops reset to 1 so a released bus never looks like an edge.
module ps2_line_sync (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic line_i,
  output logic sync_o,
  output logic fe_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fe_o   = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter driving open-drain enables for PS2_CLK/PS2_DAT.
// Define PS2_TX_TIMEOUT_EN to build the start and transfer timeout supervision.
module ps2_host_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = PS2_INHIBIT_CYCLES_DEF,
  parameter int START_TIMEOUT_CYCLES = PS2_START_TIMEOUT_CYCLES_DEF,
  parameter int XFER_TIMEOUT_CYCLES  = PS2_XFER_TIMEOUT_CYCLES_DEF
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic       cmd_error,
  output logic       tx_busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam logic [31:0] INH_LIM = 32'(INHIBIT_CYCLES);

  ps2_tx_state_e           state_q, state_d;
  logic [PS2_BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [PS2_TMR_W-1:0]    cyc_q, cyc_d;
  logic [7:0]              data_q, data_d;
  logic                    parity_q, parity_d;
  logic                    clk_oe_q, clk_oe_d;
  logic                    dat_oe_q, dat_oe_d;
  logic                    done_c, err_c;
  logic [31:0]             cyc_inc;

  logic clk_sync, clk_fe;
  logic dat_sync, dat_fe_unused;

  ps2_line_sync u_clk_sync (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .line_i   (ps2_clk_in),
    .sync_o   (clk_sync),
    .fe_o     (clk_fe)
  );

  ps2_line_sync u_dat_sync (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .line_i   (ps2_dat_in),
    .sync_o   (dat_sync),
    .fe_o     (dat_fe_unused)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [31:0] START_LIM = 32'(START_TIMEOUT_CYCLES);
  localparam logic [31:0] XFER_LIM  = 32'(XFER_TIMEOUT_CYCLES);
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^{32'(START_TIMEOUT_CYCLES), 32'(XFER_TIMEOUT_CYCLES)};
`endif

  // Cycles elapsed including the current one; a limit of 0 leaves after one cycle.
  assign cyc_inc = {{(32-PS2_TMR_W){1'b0}}, cyc_q} + 32'd1;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    cyc_d    = cyc_q;
    data_d   = data_q;
    parity_d = parity_q;
    clk_oe_d = 1'b0;
    dat_oe_d = 1'b0;
    done_c   = 1'b0;
    err_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          data_d   = cmd_data;
          parity_d = odd_parity(cmd_data);
          cyc_d    = '0;
          bitcnt_d = '0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cyc_inc >= INH_LIM) begin
          cyc_d   = '0;
          state_d = REQ;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      REQ: begin
        if (clk_fe) begin
          bitcnt_d = '0;
          cyc_d    = '0;
          state_d  = SHIFT;
        end
`ifdef PS2_TX_TIMEOUT_EN
        else if (cyc_inc >= START_LIM) begin
          state_d = ERR;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
`endif
      end
      SHIFT: begin
        // bitcnt 9 means the stop bit is on the wire; the next edge carries the ACK.
        if (clk_fe) begin
          if (bitcnt_q == 4'd9) begin
            state_d = dat_sync ? ERR : WAITIDLE;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      WAITIDLE: begin
        if (clk_sync && dat_sync) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end
      ERR: begin
        err_c   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    if (state_q == SHIFT || state_q == WAITIDLE) begin
      if (cyc_inc >= XFER_LIM) begin
        done_c  = 1'b0;
        state_d = ERR;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
`endif

    // Line enables are registered from the next state so IDLE never drives a pin.
    case (state_d)
      INHIBIT: clk_oe_d = 1'b1;
      REQ:     dat_oe_d = 1'b1;
      SHIFT: begin
        if (bitcnt_d < 4'd8) begin
          dat_oe_d = ~data_q[bitcnt_d[2:0]];
        end else if (bitcnt_d == 4'd8) begin
          dat_oe_d = ~parity_q;
        end
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      cyc_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      cyc_q    <= cyc_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    data_q   <= data_d;
    parity_q <= parity_d;
  end

  assign cmd_ready  = (state_q == IDLE);
  assign tx_busy    = (state_q != IDLE);
  assign cmd_done   = done_c & resetn;
  assign cmd_error  = err_c & resetn;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter with an open-drain bus and a simple keyboard model.
`timescale 1ns/1ps
module tb_ps2_host_transmitter;
  import ps2_pkg::*;

  localparam int INH      = 6000;
  localparam int START_TO = 3000;
  localparam int XFER_TO  = 20000;
  localparam int HALF     = 100;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, cmd_done, cmd_error, tx_busy;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int done_cyc = 0;
  int err_cyc = 0;
  int idle_oe_bad = 0;
  int overlap_cyc = 0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_transmitter #(
    .INHIBIT_CYCLES       (INH),
    .START_TIMEOUT_CYCLES (START_TO),
    .XFER_TIMEOUT_CYCLES  (XFER_TO)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_done   (cmd_done),
    .cmd_error  (cmd_error),
    .tx_busy    (tx_busy),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (cmd_done === 1'b1) done_cyc <= done_cyc + 1;
    if (cmd_error === 1'b1) err_cyc <= err_cyc + 1;
    if (cmd_done === 1'b1 && cmd_error === 1'b1) overlap_cyc <= overlap_cyc + 1;
    if (cmd_ready === 1'b1 && (ps2_clk_oe | ps2_dat_oe) !== 1'b0) idle_oe_bad <= idle_oe_bad + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Keyboard model: waits for request-to-send, clocks out 10 bits sampling on the
  // rising edge, then ACKs (or NACKs) on clock 11. stop_fe aborts with clock held low.
  task automatic dev_xfer(input bit nack, input bit inject, input int stop_fe,
                          output logic [9:0] bits, output bit ok);
    int t;
    t = 0;
    ok = 1'b1;
    bits = '0;
    while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && t < 4*INH) begin
      tick(1);
      t++;
    end
    if (t >= 4*INH) begin
      ok = 1'b0;
      return;
    end
    tick(HALF);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      if (i + 1 == stop_fe) begin
        tick(10);
        return;
      end
      if (inject && i == 3) begin
        cmd_data  = 8'hFF;
        cmd_valid = 1'b1;
      end
      if (inject && i == 5) begin
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
      end
      tick(HALF);
      dev_clk_low = 1'b0;
      bits[i] = ps2_dat_in;
      tick(HALF);
    end
    dev_dat_low = ~nack;
    tick(HALF/2);
    dev_clk_low = 1'b1;
    tick(HALF);
    dev_clk_low = 1'b0;
    tick(HALF/2);
    dev_dat_low = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick(3);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    n_checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin n_fail++; $display("FAIL reset_oe: got %b expected 00", {ps2_clk_oe, ps2_dat_oe}); end
    n_checks++; if ({cmd_done, cmd_error} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {cmd_done, cmd_error}); end
    resetn = 1'b1;
    tick(2);
    n_checks++; if (cmd_ready !== 1'b1 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got ready=%b busy=%b expected 1/0", cmd_ready, tx_busy); end
  endtask

  task automatic test_transfer(input logic [7:0] b, input logic par, input bit nack, input bit inject);
    int n, d0, e0;
    logic [9:0] bits, exp_bits;
    bit ok;
    exp_bits = {1'b1, par, b};
    d0 = done_cyc;
    e0 = err_cyc;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_before %02h: got %b expected 1", b, cmd_ready); end
    cmd_data  = b;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    n_checks++; if ({tx_busy, ps2_clk_oe, ps2_dat_oe} !== 3'b110) begin n_fail++; $display("FAIL accept %02h: got busy/clk/dat=%b expected 110", b, {tx_busy, ps2_clk_oe, ps2_dat_oe}); end
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 4*INH) begin
      tick(1);
      n++;
    end
    n_checks++; if (n !== INH) begin n_fail++; $display("FAIL inhibit_len %02h: got %0d expected %0d", b, n, INH); end
    n_checks++; if (ps2_dat_oe !== 1'b1) begin n_fail++; $display("FAIL start_bit %02h: got dat_oe=%b expected 1", b, ps2_dat_oe); end
    dev_xfer(nack, inject, 99, bits, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rts_seen %02h: got %b expected 1", b, ok); end
    n_checks++; if (bits !== exp_bits) begin n_fail++; $display("FAIL frame_bits %02h: got %b expected %b", b, bits, exp_bits); end
    n = 0;
    while (done_cyc == d0 && err_cyc == e0 && n < 200) begin
      tick(1);
      n++;
    end
    tick(5);
    n_checks++; if (done_cyc - d0 !== (nack ? 0 : 1)) begin n_fail++; $display("FAIL done_cycles %02h: got %0d expected %0d", b, done_cyc - d0, nack ? 0 : 1); end
    n_checks++; if (err_cyc - e0 !== (nack ? 1 : 0)) begin n_fail++; $display("FAIL error_cycles %02h: got %0d expected %0d", b, err_cyc - e0, nack ? 1 : 0); end
    n_checks++; if ({cmd_ready, tx_busy, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin n_fail++; $display("FAIL end_idle %02h: got ready/busy/clk/dat=%b expected 1000", b, {cmd_ready, tx_busy, ps2_clk_oe, ps2_dat_oe}); end
  endtask

  task automatic test_reset_mid;
    int d0, e0;
    logic [9:0] bits;
    bit ok;
    cmd_data  = 8'h55;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    dev_xfer(1'b0, 1'b0, 5, bits, ok);
    n_checks++; if (ok !== 1'b1 || tx_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got ok=%b busy=%b expected 1/1", ok, tx_busy); end
    d0 = done_cyc;
    e0 = err_cyc;
    resetn = 1'b0;
    tick(1);
    n_checks++; if ({tx_busy, ps2_clk_oe, ps2_dat_oe} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_state: got busy/clk/dat=%b expected 000", {tx_busy, ps2_clk_oe, ps2_dat_oe}); end
    resetn = 1'b1;
    dev_clk_low = 1'b0;
    tick(20);
    n_checks++; if (done_cyc != d0 || err_cyc != e0) begin n_fail++; $display("FAIL mid_reset_pulses: got done=%0d err=%0d expected 0/0", done_cyc - d0, err_cyc - e0); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_no_clock;
    int n, d0, e0;
    d0 = done_cyc;
    e0 = err_cyc;
    cmd_data  = PS2_CMD_RESET;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < 4*INH) begin
      tick(1);
      n++;
    end
    n_checks++; if (n !== INH) begin n_fail++; $display("FAIL noclk_inhibit: got %0d expected %0d", n, INH); end
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (cmd_error !== 1'b1 && n < 2*START_TO) begin
      tick(1);
      n++;
    end
    n_checks++; if (n !== START_TO) begin n_fail++; $display("FAIL start_timeout: got %0d cycles expected %0d", n, START_TO); end
    tick(3);
    n_checks++; if (err_cyc - e0 !== 1 || done_cyc != d0) begin n_fail++; $display("FAIL timeout_pulses: got err=%0d done=%0d expected 1/0", err_cyc - e0, done_cyc - d0); end
    n_checks++; if ({cmd_ready, ps2_clk_oe, ps2_dat_oe} !== 3'b100) begin n_fail++; $display("FAIL timeout_idle: got %b expected 100", {cmd_ready, ps2_clk_oe, ps2_dat_oe}); end
`else
    tick(2*START_TO);
    n_checks++; if (tx_busy !== 1'b1 || ps2_dat_oe !== 1'b1) begin n_fail++; $display("FAIL noclk_wait: got busy=%b dat_oe=%b expected 1/1", tx_busy, ps2_dat_oe); end
    n_checks++; if (err_cyc != e0 || done_cyc != d0) begin n_fail++; $display("FAIL noclk_pulses: got err=%0d done=%0d expected 0/0", err_cyc - e0, done_cyc - d0); end
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(2);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL noclk_recover: got %b expected 1", cmd_ready); end
`endif
  endtask

  task automatic test_monitors;
    n_checks++; if (idle_oe_bad != 0) begin n_fail++; $display("FAIL idle_oe: got %0d cycles expected 0", idle_oe_bad); end
    n_checks++; if (overlap_cyc != 0) begin n_fail++; $display("FAIL done_error_overlap: got %0d cycles expected 0", overlap_cyc); end
  endtask

  initial begin
    test_reset;
    test_transfer(PS2_CMD_SET_LEDS, 1'b1, 1'b0, 1'b0);
    test_transfer(8'h00, 1'b1, 1'b0, 1'b0);
    test_transfer(PS2_CMD_ENABLE, 1'b0, 1'b1, 1'b0);
    test_transfer(8'hF0, 1'b1, 1'b0, 1'b1);
    test_reset_mid;
    test_no_clock;
    test_monitors;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
